// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and width helpers for the Booth multiplier
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One guard bit lets the signed most-negative square fit without overflow.
  function automatic int ext_width(input int width);
    return width + 1;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_mult_param_if.sv
// rtl/booth_mult_param_if.sv - start/busy/done handshake bundle for booth_mult_param
interface booth_mult_param_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     mc;
  logic [WIDTH-1:0]     mp;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   prod;

  modport master (
    output start, signed_mode, mc, mp,
    input  busy, done, prod
  );

  modport slave (
    input  start, signed_mode, mc, mp,
    output busy, done, prod
  );
endinterface

// File: rtl/booth_addsub.sv
// rtl/booth_addsub.sv - W-bit adder with carry-in; carry-out is dropped
module booth_addsub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  assign sum = a + b + {{(W-1){1'b0}}, cin};

endmodule

// File: rtl/booth_mult_param.sv
// rtl/booth_mult_param.sv - sequential radix-2 Booth multiplier, signed or unsigned per operation
module booth_mult_param
  import booth_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  booth_mult_param_if.slave  bus
);

  localparam int E  = ext_width(WIDTH);
  localparam int CW = cnt_width(WIDTH);

  state_t             state, state_nxt;
  logic [E-1:0]       a, q, m;
  logic               q_1;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;

  logic [E-1:0]       sum_add, sum_sub, a_op, a_sh, q_sh;
  logic               load, last, busy, done;

  booth_addsub #(.W(E)) u_add (.a(a), .b(m),  .cin(1'b0), .sum(sum_add));
  booth_addsub #(.W(E)) u_sub (.a(a), .b(~m), .cin(1'b1), .sum(sum_sub));

  always_comb begin
    case ({q[0], q_1})
      2'b01:   a_op = sum_add;
      2'b10:   a_op = sum_sub;
      default: a_op = a;
    endcase
  end

  // Arithmetic shift of {A,Q,Q_1}: new A's MSB is replicated.
  assign a_sh = {a_op[E-1], a_op[E-1:1]};
  assign q_sh = {a_op[0], q[E-1:1]};
  assign last = (cnt == CW'(E - 1));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      q     <= '0;
      m     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      prod  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        a   <= '0;
        q   <= {bus.signed_mode & bus.mp[WIDTH-1], bus.mp};
        m   <= {bus.signed_mode & bus.mc[WIDTH-1], bus.mc};
        q_1 <= 1'b0;
        cnt <= '0;
      end else if (state == RUN) begin
        a   <= a_sh;
        q   <= q_sh;
        q_1 <= q[0];
        cnt <= cnt + CW'(1);
        // The two guard bits at the top of {A,Q} are dropped from the product.
        if (last) prod <= {a_sh[E-3:0], q_sh};
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.prod = prod;

endmodule

// File: doc/booth_mult_param.md
# booth_mult_param

Parametrised sequential radix-2 Booth multiplier, the next generation of the lab's 4-bit Booth multiplier. It is generalised to any operand width and selects signed or unsigned operation per transaction. It adds an asynchronous active-low reset, a start/busy/done handshake with a fixed latency, and a product register that holds its value between operations. It sits as a leaf arithmetic unit under a controller or testbench that issues one multiply at a time.

## Interface
- WIDTH, default 4: operand width in bits; must be at least 2.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a multiply; sampled only when busy=0.
- signed_mode  input  1  operand interpretation; 1 = two's complement, 0 = unsigned. Captured with start.
- mc  input  WIDTH  multiplicand; captured with start.
- mp  input  WIDTH  multiplier; captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when prod becomes valid.
- prod  output  2*WIDTH  product register; holds its value until the next accepted start.

## Operation
- Internal datapath width is E = WIDTH+1 for both signed and unsigned operation.
  - Unsigned: operands are zero-extended to E bits.
  - Signed: operands are sign-extended to E bits.
- Registers:
  - A[E-1:0], Q[E-1:0], M[E-1:0], Q_1, and iteration counter cnt of width clog2(E+1).
  - On an accepted start: A=0, Q=ext(mp), M=ext(mc), Q_1=0, cnt=0.
- Per RUN cycle, decode {Q[0],Q_1}:
  - 01: A = A+M.
  - 10: A = A-M, computed as A + ~M + 1.
  - 00 or 11: A is unchanged.
  - Then arithmetic-shift-right of {A,Q,Q_1}, replicating the MSB of the new A. cnt increments.
- Exactly E iterations are performed. The final {A,Q} is 2E bits; prod = {A,Q}[2*WIDTH-1:0].
- The result is exact for every operand pair in both modes. This includes signed most-negative times most-negative, because the extra guard bit covers it.
- State machine with three states:
  - IDLE: busy=0. On start, load registers and go to RUN.
  - RUN: busy=1. When the cnt==E-1 iteration completes, go to DONE and write prod.
  - DONE: busy=0, done=1 for this cycle only. On start, load registers and go to RUN; otherwise go to IDLE.
- start is ignored while in RUN; captured operands are not disturbed.
- mc, mp and signed_mode may change freely after the start cycle.

## Timing
- Reset state: IDLE, busy=0, done=0, prod=0, and all internal registers 0. Reset is asynchronous assert; the design must still release cleanly on a clock edge.
- Reset during RUN aborts the operation immediately. Everything returns to the reset values, and no done pulse is produced.
- Start at edge t: busy=1 from t+1 through t+E inclusive.
- At edge t+E+1: prod is updated, done=1, busy=0.
- Latency from start to done is E+1 = WIDTH+2 cycles, independent of the data.
- Back-to-back: start asserted in the DONE cycle is accepted. The next done follows WIDTH+2 cycles later.
- A held-high start re-triggers each time busy=0.
- prod changes only on DONE entry and on reset.

## Structure
- Shared package booth_pkg holds:
  - The state typedef (IDLE, RUN, DONE).
  - A function or localparam deriving E and the counter width from WIDTH.
- One sub-module, booth_addsub: a parametrised E-bit adder with carry-in. It is instantiated once with (A, M, 0) and once with (A, ~M, 1). Its output is the sum only, and carry-out is discarded.
- Everything else stays in booth_mult_param: FSM, counter, shift register and product register.

## Test plan
- WIDTH=4, signed, mc=3, mp=-2 (4'hE) -> after 6 cycles, done pulses and prod=8'hFA.
- WIDTH=4, unsigned, mc=15, mp=15 -> prod=8'hE1; signed, mc=-8, mp=-8 -> prod=8'h40.
- WIDTH=8: unsigned 255×255 -> prod=16'hFE01; signed -128×127 -> prod=16'hC080. Latency is 10 cycles in both cases.
- WIDTH=4, start again mid-RUN with different operands -> ignored; the original product is delivered on schedule.
- WIDTH=4, rst_n pulsed low during RUN -> busy=0, done stays 0, prod=0. A following start with 2×3 -> prod=8'h06.
- WIDTH=4, start held high across two operations (5×5, then 7×-1 signed) -> prod=8'h19, then 8'hF9. The two done pulses are 6 cycles apart.
